uart_tx_arbiter: RTL and testbench

Shares the single byte-wide UART transmitter core between N_REQ byte producers (telemetry, debug, command echo) using round-robin arbitration.
- Accepts one byte per grant over a valid/ready handshake.
- Drives the core's run_req/wdata, waits for the core's end_flag, then enforces an inter-frame gap before the next grant.
- Sits between the flight-controller producers and the UART core; it is the only driver of the core's run_req.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_picker.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit path.
package uart_pkg;

  // Arbiter frame sequencing states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_END = 2'd2,
    GAP      = 2'd3
  } arb_state_e;

  // Idle cycles after a frame ends; two covers the core's STOP cycle.
  localparam int GAP_CYC_DEF = 2;

  // WAIT_END cycle limit; comfortably above a full byte frame.
  localparam int TIMEOUT_DEF = 64;

endpackage : uart_pkg

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first set request bit at or
// above the pointer, wrapping past N_REQ-1 back to 0.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_valid_o,
  output logic [IDX_W-1:0] sel_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] idx_s;

  // Scan N_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    any_valid_o = 1'b0;
    sel_o       = {IDX_W{1'b0}};
    idx_s       = {SUM_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = {1'b0, ptr_i} + SUM_W'(k);
      if (idx_s >= SUM_W'(N_REQ)) begin
        idx_s = idx_s - SUM_W'(N_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!any_valid_o && req_i[idx_s]) begin
        any_valid_o = 1'b1;
        sel_o       = idx_s[IDX_W-1:0];
      end else begin
        any_valid_o = any_valid_o;
        sel_o       = sel_o;
      end
    end
  end

endmodule : rr_picker

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter core between N_REQ byte
// producers. One byte per grant; waits for the core's end_flag edge (or a
// timeout) and then holds an inter-frame gap before the next grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          core_wdata,
  output logic                       core_run_req,
  input  logic                       core_end_flag,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam int GCNT_W = $clog2(GAP_CYC);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);
  localparam logic [GCNT_W-1:0] GAP_LOAD = GCNT_W'(GAP_CYC - 1);

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = {N_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              end_prev_q;

  logic              any_valid_s;
  logic [IDX_W-1:0]  sel_s;
  logic              edge_s;
  logic              tout_s;
  logic [N_REQ-1:0]  ready_s;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i       (req_valid),
    .ptr_i       (rr_q),
    .any_valid_o (any_valid_s),
    .sel_o       (sel_s)
  );

  // The edge detector tracks end_flag in every state; only WAIT_END acts on it.
  assign edge_s = core_end_flag & ~end_prev_q;

  // Next-state and datapath updates for the grant/issue/wait/gap sequence.
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    tout_s  = 1'b0;
    ready_s = {N_REQ{1'b0}};
    case (state_q)
      IDLE: begin
        if (any_valid_s) begin
          ready_s = onehot(sel_s);
          wdata_d = req_data[int'(sel_s)*DATA_W +: DATA_W];
          grant_d = sel_s;
          rr_d    = (sel_s == LAST_IDX) ? {IDX_W{1'b0}} : sel_s + IDX_W'(1);
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        tcnt_d  = {TCNT_W{1'b0}};
        state_d = WAIT_END;
      end
      WAIT_END: begin
        // An edge on the last allowed cycle is a normal end, not a timeout.
        if (edge_s) begin
          gcnt_d  = GAP_LOAD;
          state_d = GAP;
        end else if (tcnt_q == TCNT_MAX) begin
          tout_s  = 1'b1;
          gcnt_d  = GAP_LOAD;
          state_d = GAP;
        end else begin
          tcnt_d  = tcnt_q + TCNT_W'(1);
        end
      end
      GAP: begin
        if (gcnt_q == {GCNT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          gcnt_d  = gcnt_q - GCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wdata_q    <= {DATA_W{1'b0}};
      grant_q    <= {IDX_W{1'b0}};
      rr_q       <= {IDX_W{1'b0}};
      tcnt_q     <= {TCNT_W{1'b0}};
      gcnt_q     <= {GCNT_W{1'b0}};
      end_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdata_q    <= wdata_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      tcnt_q     <= tcnt_d;
      gcnt_q     <= gcnt_d;
      end_prev_q <= core_end_flag;
    end
  end

  // Ready is a same-cycle accept; it is forced low while reset is asserted.
  assign req_ready    = rst_n ? ready_s : {N_REQ{1'b0}};
  assign core_wdata   = wdata_q;
  assign grant_id     = grant_q;
  assign core_run_req = (state_q == ISSUE);
  assign busy         = (state_q != IDLE);
  assign timeout_err  = tout_s;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small UART core model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [31:0] req_data = 32'd0;
  logic [3:0]  req_ready;
  logic [7:0]  core_wdata;
  logic        core_run_req;
  logic        core_end_flag = 1'b0;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYC(2), .TIMEOUT(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .core_wdata    (core_wdata),
    .core_run_req  (core_run_req),
    .core_end_flag (core_end_flag),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } run_t;

  logic [3:0] rdy_q[$];
  run_t       run_q[$];
  int errors = 0;
  int checks = 0;
  int rdy_seen = 0;
  int run_seen = 0;
  int tout_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input int id, input logic [7:0] d);
    logic [3:0] one;
    run_t e;
    one = 4'b0001;
    rdy_q.push_back(one << id);
    e.id = id[1:0];
    e.data = d;
    run_q.push_back(e);
  endtask

  // Core model: end_flag rises core_lat cycles after run_req, held core_hold cycles.
  int core_lat = 11;
  int core_hold = 1;
  bit core_dead = 1'b0;
  int cdown = 0;
  int hold = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cdown = 0;
      hold = 0;
      core_end_flag = 1'b0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) core_end_flag = 1'b0;
      end
      if (cdown > 0) begin
        cdown--;
        if (cdown == 0) begin
          core_end_flag = 1'b1;
          hold = core_hold;
        end
      end
      if (core_run_req && !core_dead) cdown = core_lat;
    end
  end

  // Monitor: pop and compare whenever the DUT presents a ready or a run_req.
  logic prev_rdy = 1'b0;
  logic [3:0] mon_rdy;
  run_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
    end else begin
      if (req_ready != 4'd0) begin
        rdy_seen++;
        if (rdy_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: actual=0x%0h required=none", req_ready);
        end else begin
          mon_rdy = rdy_q.pop_front();
          chk("req_ready", {28'd0, req_ready}, {28'd0, mon_rdy});
        end
      end
      if (core_run_req) begin
        run_seen++;
        chk("ready_then_run", {31'd0, prev_rdy}, 32'd1);
        if (run_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_run: actual grant=%0d required=none", grant_id);
        end else begin
          mon_e = run_q.pop_front();
          chk("core_wdata", {24'd0, core_wdata}, {24'd0, mon_e.data});
          chk("grant_id", {30'd0, grant_id}, {30'd0, mon_e.id});
        end
      end
      if (timeout_err) tout_cnt++;
      prev_rdy = (req_ready != 4'd0);
    end
  end

  task automatic set_data(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, {28'd0, req_ready}, 32'd0);
    chk({tag, "_run_req"}, {31'd0, core_run_req}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, core_wdata}, 32'd0);
    chk({tag, "_grant_id"}, {30'd0, grant_id}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
  endtask

  // Wait for req_ready[idx], then drop that requester's valid after the handshake edge.
  task automatic wait_rdy(input int idx);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("wait_ready_r%0d", idx), {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_idle", {31'd0, got}, 32'd1);
  endtask

  // Cycles from the run_req cycle until busy first reads low.
  task automatic measure_busy(output int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (core_run_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("run_req_seen", {31'd0, seen}, 32'd1);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
  endtask

  int n;
  int base;
  bit got;

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");

    // All four valid: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    expect_grant(0, 8'h10);
    expect_grant(1, 8'h11);
    expect_grant(2, 8'h12);
    expect_grant(3, 8'h13);
    expect_grant(0, 8'h10);
    base = rdy_seen;
    @(posedge clk);
    #1;
    req_valid = 4'b1111;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rdy_seen >= base + 5) begin
        got = 1'b1;
        break;
      end
    end
    chk("five_grants", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    wait_idle();

    // Single requester 2: ready, then run_req next cycle, idle after end + gap.
    set_data(2, 8'hA5);
    expect_grant(2, 8'hA5);
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    wait_rdy(2);
    measure_busy(n);
    chk("frame_to_idle", n, 32'd14);

    // Bring rr_ptr to 2 via a grant to 1, then 1 and 3 valid: 3 first, then 1.
    set_data(1, 8'h5A);
    set_data(3, 8'hC3);
    expect_grant(1, 8'h5A);
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    wait_rdy(1);
    wait_idle();
    expect_grant(3, 8'hC3);
    expect_grant(1, 8'h5A);
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    wait_rdy(3);
    wait_rdy(1);
    wait_idle();
    chk("grant_id_holds", {30'd0, grant_id}, 32'd1);

    // Dead core: one timeout pulse 64 cycles after ISSUE, then recovery.
    core_dead = 1'b1;
    base = tout_cnt;
    set_data(2, 8'h77);
    set_data(0, 8'h01);
    expect_grant(2, 8'h77);
    expect_grant(0, 8'h01);
    @(posedge clk);
    #1;
    req_valid = 4'b0101;
    wait_rdy(2);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (core_run_req) begin
        got = 1'b1;
        break;
      end
    end
    chk("dead_run_req", {31'd0, got}, 32'd1);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (timeout_err) break;
    end
    chk("timeout_latency", n, 32'd64);
    @(posedge clk);
    #1;
    core_dead = 1'b0;
    wait_rdy(0);
    wait_idle();
    chk("timeout_pulses", tout_cnt - base, 32'd1);

    // Reset in WAIT_END: outputs clear at once; rr_ptr restarts at 0.
    set_data(2, 8'h44);
    expect_grant(2, 8'h44);
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    wait_rdy(2);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    set_data(0, 8'h3C);
    set_data(3, 8'hE1);
    req_valid = 4'b1001;
    #1;
    chk_zero("async_reset");
    repeat (2) @(posedge clk);
    #3;
    expect_grant(0, 8'h3C);
    expect_grant(3, 8'hE1);
    rst_n = 1'b1;
    wait_rdy(0);
    wait_rdy(3);
    wait_idle();

    // end_flag held 3 cycles: one completion, normal gap, no extra grant.
    core_hold = 3;
    set_data(1, 8'h99);
    expect_grant(1, 8'h99);
    @(posedge clk);
    #1;
    req_valid = 4'b0010;
    wait_rdy(1);
    measure_busy(n);
    chk("held_flag_frame", n, 32'd14);
    base = run_seen;
    repeat (20) @(negedge clk);
    chk("no_extra_grant", run_seen - base, 32'd0);
    chk("stays_idle", {31'd0, busy}, 32'd0);

    // end_flag still high when the next frame enters WAIT_END must not end it.
    core_hold = 6;
    set_data(1, 8'hAB);
    set_data(2, 8'hCD);
    expect_grant(2, 8'hCD);
    expect_grant(1, 8'hAB);
    @(posedge clk);
    #1;
    req_valid = 4'b0110;
    wait_rdy(2);
    measure_busy(n);
    chk("b2b_frame1", n, 32'd14);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    measure_busy(n);
    chk("b2b_frame2", n, 32'd14);
    repeat (20) @(negedge clk);

    chk("rdy_q_empty", rdy_q.size(), 32'd0);
    chk("run_q_empty", run_q.size(), 32'd0);
    chk("total_timeouts", tout_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
